// File: rtl/freq_divider_prog.sv
// Runtime-programmable integer clock divider with once-per-period tick.
// A new divisor is staged and applied only at a period boundary or while idle.
//
// state | meaning
// IDLE  | output parked low, pending divisor applied every edge
// RUN   | counting 0..cur_div-1, clk_out high for floor(cur_div/2) cycles
module freq_divider_prog #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 12,
    parameter int ODD_HALF    = 0
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_cur
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cur_div, cur_div_nxt;
    logic [CNT_W-1:0] pend_div, pend_div_nxt;
    logic [CNT_W-1:0] load_val, half;
    logic             pend_vld, pend_vld_nxt;
    logic             clk_r, clk_r_nxt;
    logic             tick_nxt;
    logic             wrap, apply;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = '0;
        clk_r_nxt    = 1'b0;
        tick_nxt     = 1'b0;
        apply        = 1'b0;
        cur_div_nxt  = cur_div;
        pend_div_nxt = pend_div;
        pend_vld_nxt = pend_vld;
        load_val     = (div_in < DIV_MIN) ? DIV_MIN : div_in;
        half         = cur_div >> 1;
        wrap         = (cnt == cur_div - ONE);

        case (state)
            IDLE: begin
                apply = 1'b1;
                if (en) begin
                    state_nxt = RUN;
                    clk_r_nxt = 1'b1;
                    tick_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (wrap) begin
                    apply     = 1'b1;
                    clk_r_nxt = 1'b1;
                    tick_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + ONE;
                    clk_r_nxt = ((cnt + ONE) < half);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (div_load) begin
            pend_div_nxt = load_val;
        end
        // A load coinciding with a boundary bypasses the staging register.
        if (apply) begin
            if (div_load) begin
                cur_div_nxt  = load_val;
                pend_vld_nxt = 1'b0;
            end else if (pend_vld) begin
                cur_div_nxt  = pend_div;
                pend_vld_nxt = 1'b0;
            end
        end else if (div_load) begin
            pend_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clk_r    <= 1'b0;
            tick     <= 1'b0;
            cur_div  <= DIV_RST;
            pend_div <= '0;
            pend_vld <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            clk_r    <= clk_r_nxt;
            tick     <= tick_nxt;
            cur_div  <= cur_div_nxt;
            pend_div <= pend_div_nxt;
            pend_vld <= pend_vld_nxt;
        end
    end

    assign div_cur = cur_div;

    generate
        if (ODD_HALF != 0) begin : g_odd_half
            logic neg_q;
            // Half-cycle stretch of the high phase makes odd divisors exactly 50% duty.
            always_ff @(negedge clk_in or negedge rst_n) begin
                if (!rst_n) begin
                    neg_q <= 1'b0;
                end else begin
                    neg_q <= clk_r;
                end
            end
            assign clk_out = clk_r | (cur_div[0] & neg_q);
        end else begin : g_rise_only
            assign clk_out = clk_r;
        end
    endgenerate

endmodule

// File: doc/freq_divider_prog.md
Name: freq_divider_prog

Overview:
- Runtime-programmable integer clock divider; successor to the fixed-parameter frequency_divider.
- Adds enable/restart, a divisor that can be reloaded at runtime without glitches, a once-per-period tick, and an optional exact 50% duty cycle for odd divisors.
- Sits in the clock-enable / LED / baud-timing path.
- clk_out is a logic-derived clock; downstream blocks should use tick as a clock enable.

Parameters:
- CNT_W, 16, width of the divisor and the internal counter.
- DEFAULT_DIV, 12, divisor loaded at reset; must satisfy 2 <= DEFAULT_DIV < 2^CNT_W.
- ODD_HALF, 0, 1 = add a falling-edge stage giving exactly 50% duty for odd divisors; 0 = rising-edge logic only.

Ports:
- clk_in, input, 1, system clock; all registers use the rising edge except the ODD_HALF stage.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, run enable; low forces the idle state.
- div_in, input, CNT_W, new divisor N.
- div_load, input, 1, one-cycle strobe that captures div_in.
- clk_out, output, 1, divided clock.
- tick, output, 1, one-cycle pulse on the first cycle of each output period.
- div_cur, output, CNT_W, divisor currently in effect.

Behaviour:
- Reset (async assert, removal sync to clk_in):
  - state=IDLE, cnt=0, clk_out=0, tick=0.
  - cur_div=DEFAULT_DIV, pend_div=0, pend_vld=0, neg stage=0.
- Divisor capture:
  - At an edge with div_load=1, pend_div<=max(div_in,2) and pend_vld<=1.
  - Values 0 and 1 are clamped to 2.
  - A later load overwrites a pending one.
- Divisor apply:
  - The pending divisor is applied only at a period boundary (a RUN wrap or the IDLE->RUN start) or while idle.
  - Applying it sets cur_div<=pend_div and pend_vld<=0.
  - If div_load is asserted on the same edge as an apply, div_in (clamped) is applied directly and pend_vld stays 0.
- H = floor(cur_div/2), computed from the divisor in effect for the cycle being produced.
- IDLE, on each edge:
  - cnt<=0, clk_out<=0, tick<=0; any pending divisor is applied.
  - If en=1: go to RUN with cnt<=0, clk_out<=1, tick<=1, using the (possibly new) divisor.
- RUN with en=1, on each edge:
  - If cnt==cur_div-1 (wrap): cnt<=0, tick<=1, clk_out<=1, apply pending divisor.
  - Otherwise: cnt<=cnt+1, tick<=0, clk_out<=((cnt+1)<H).
- RUN with en=0: next edge goes to IDLE with cnt<=0, clk_out<=0, tick<=0. Restarting always begins a fresh period.
- Resulting waveform:
  - Output period is N clk_in cycles.
  - clk_out is high for H cycles and low for N-H cycles.
  - tick coincides with the first high cycle.
  - Latency from en rising to the first clk_out high is one edge.
- ODD_HALF=1:
  - A falling-edge flop samples the rising-edge clk_out register.
  - When cur_div is odd, clk_out = rising-edge register OR falling-edge flop. This gives a high time of H+0.5 cycles, which is exactly 50% duty.
  - When cur_div is even, clk_out = rising-edge register only.
  - tick is unaffected.
- Counter never exceeds cur_div-1. Shrinking the divisor mid-period has no effect until the wrap, so no runt pulses occur.
- Reset mid-operation returns everything to the reset values immediately; no partial period is emitted.
- div_cur = cur_div.

Test Plan:
- Reset release, en=1, DEFAULT_DIV=12, clock period 20 ns, run 100 cycles -> clk_out period 240 ns, high 120 ns; tick high 20 ns every 240 ns; first tick on the first edge after en rises; 8 full periods plus a partial.
- div_load with div_in=4 at cnt=3 of a 12-cycle period -> the current period completes all 12 cycles; next period is 4 cycles (high 2, low 2); div_cur changes to 4 at the wrap edge.
- div_in=0, then div_in=1 -> both treated as 2: clk_out toggles every cycle, tick on every other cycle, div_cur=2.
- ODD_HALF=1, div_in=5 -> clk_out high 50 ns, low 50 ns; ODD_HALF=0 with the same stimulus -> high 40 ns, low 60 ns.
- en dropped at cnt=7, then re-raised after 3 cycles -> clk_out=0 and tick=0 while idle; a fresh period starts (tick=1, clk_out=1) one edge after en rises; a divisor loaded while idle is applied before the restart.
- rst_n asserted mid-high phase -> clk_out, tick and cnt clear immediately; div_cur returns to 12.
